// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step controller for the simple MIPS core.
// Holds the core in reset for RST_CYCLES after a controller reset or a restart. It then
// enables the core either continuously (MODE_RUN=1) or for STEP_CYCLES per debounced press
// of KEY_OK. The core is stopped when it raises HALT_REQ.
// Ports:
//   CLK       system clock, rising edge
//   RST       synchronous reset, active-high
//   KEY_OK    raw push-button, active-low, asynchronous to CLK
//   MODE_RUN  1 = free-run, 0 = single-step
//   HALT_REQ  1-cycle pulse from the core: halt instruction retired
//   CPU_EN    core clock enable (registered)
//   CPU_RST   core reset, active-high (registered)
//   STEP_CNT  enabled cycles since the last restart, saturating
//   STATE     current FSM state encoding
//   LED_Out   {halt, run, step, STEP_CNT[0]}
module cpu_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned RST_CYCLES      = 4,
  parameter int unsigned STEP_CYCLES     = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             KEY_OK,
  input  logic             MODE_RUN,
  input  logic             HALT_REQ,
  output logic             CPU_EN,
  output logic             CPU_RST,
  output logic [CNT_W-1:0] STEP_CNT,
  output logic [2:0]       STATE,
  output logic [3:0]       LED_Out
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned SC_W = $clog2(STEP_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RST_CYCLES - 1);
  localparam logic [SC_W-1:0] STEP_LOAD = SC_W'(STEP_CYCLES);

  typedef enum logic [2:0] {
    S_INIT = 3'b000,
    S_WAIT = 3'b001,
    S_RUN  = 3'b010,
    S_STEP = 3'b011,
    S_HALT = 3'b100
  } state_t;

  state_t          state_q, state_d;
  logic            key_s1, key_s2, key_db, key_db_d, key_press;
  logic [DB_W-1:0] db_cnt;
  logic [RC_W-1:0] init_cnt;
  logic [SC_W-1:0] step_tmr;
  logic [2:0]      led_q;

  // Key path: two-flop synchronizer, then a stability counter. key_db follows key_s2 only
  // after DEBOUNCE_CYCLES consecutive samples that differ from it; any sample equal to
  // key_db restarts the count. key_press is the registered falling edge of key_db.
  always_ff @(posedge CLK) begin
    if (RST) begin
      key_s1    <= 1'b1;
      key_s2    <= 1'b1;
      key_db    <= 1'b1;
      key_db_d  <= 1'b1;
      key_press <= 1'b0;
      db_cnt    <= '0;
    end else begin
      key_s1    <= KEY_OK;
      key_s2    <= key_s1;
      key_db_d  <= key_db;
      key_press <= key_db_d & ~key_db;
      if (key_s2 == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= key_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: if (init_cnt == RC_LAST) state_d = S_WAIT;
      S_WAIT: begin
        if (MODE_RUN)       state_d = S_RUN;
        else if (key_press) state_d = S_STEP;
      end
      S_RUN: begin
        if (HALT_REQ)       state_d = S_HALT;
        else if (!MODE_RUN) state_d = S_WAIT;
      end
      S_STEP: begin
        if (HALT_REQ)                   state_d = S_HALT;
        else if (step_tmr <= SC_W'(1))  state_d = S_WAIT;
      end
      S_HALT: if (key_press) state_d = S_INIT;
      default: state_d = S_INIT;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with STATE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_INIT;
      init_cnt <= '0;
      step_tmr <= '0;
      CPU_EN   <= 1'b0;
      CPU_RST  <= 1'b1;
      STEP_CNT <= '0;
      led_q    <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == S_INIT && state_d == S_INIT) init_cnt <= init_cnt + 1'b1;
      else                                        init_cnt <= '0;

      if (state_d == S_STEP && state_q != S_STEP) step_tmr <= STEP_LOAD;
      else if (state_q == S_STEP)                 step_tmr <= step_tmr - 1'b1;

      CPU_EN  <= (state_d == S_RUN) || (state_d == S_STEP);
      CPU_RST <= (state_d == S_INIT);
      led_q   <= {state_d == S_HALT, state_d == S_RUN, state_d == S_STEP};

      // Cleared on entry to S_INIT so a restart shows zero immediately.
      if (state_d == S_INIT)              STEP_CNT <= '0;
      else if (CPU_EN && STEP_CNT != '1)  STEP_CNT <= STEP_CNT + 1'b1;
    end
  end

  assign STATE   = state_q;
  assign LED_Out = {led_q, STEP_CNT[0]};

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a default instance plus one with CNT_W=4, STEP_CYCLES=5.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_ok = 1'b1;
  logic        mode_run = 1'b0;
  logic        halt_req = 1'b0;

  logic        cpu_en, cpu_rst;
  logic [15:0] step_cnt;
  logic [2:0]  state;
  logic [3:0]  led;

  logic        s_cpu_en, s_cpu_rst;
  logic [3:0]  s_step_cnt;
  logic [2:0]  s_state;
  logic [3:0]  s_led;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .CLK(clk), .RST(rst), .KEY_OK(key_ok), .MODE_RUN(mode_run), .HALT_REQ(halt_req),
    .CPU_EN(cpu_en), .CPU_RST(cpu_rst), .STEP_CNT(step_cnt), .STATE(state), .LED_Out(led)
  );

  cpu_run_ctrl #(.CNT_W(4), .STEP_CYCLES(5)) dut_s (
    .CLK(clk), .RST(rst), .KEY_OK(key_ok), .MODE_RUN(mode_run), .HALT_REQ(halt_req),
    .CPU_EN(s_cpu_en), .CPU_RST(s_cpu_rst), .STEP_CNT(s_step_cnt), .STATE(s_state),
    .LED_Out(s_led)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    mode_run = 1'b0; halt_req = 1'b0; key_ok = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++; if (state !== 3'b000) begin errors++; $display("FAIL reset_state: got %b exp 000", state); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b exp 0", cpu_en); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpurst: got %b exp 1", cpu_rst); end
    checks++; if (step_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", step_cnt); end
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL reset_led: got %b exp 0000", led); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (cpu_rst !== 1'b1 || state !== 3'b000) begin
        errors++; $display("FAIL init_hold[%0d]: got rst=%b st=%b exp rst=1 st=000", i, cpu_rst, state);
      end
      tick;
    end
    checks++; if (state !== 3'b001) begin errors++; $display("FAIL init_to_wait: got %b exp 001", state); end
    checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL init_release: got %b exp 0", cpu_rst); end
    checks++; if (cpu_en !== 1'b0 || led !== 4'b0000) begin
      errors++; $display("FAIL wait_outputs: got en=%b led=%b exp en=0 led=0000", cpu_en, led);
    end
  endtask

  task automatic test_step;
    logic [9:0] pat;
    int first_en, en_cnt, led1_cnt;
    pat = 10'b0000001010;   // bounces high in cycles 1 and 3
    first_en = -1; en_cnt = 0; led1_cnt = 0;
    mode_run = 1'b0;
    for (int i = 0; i < 30; i++) begin
      key_ok = (i < 10) ? pat[i] : 1'b1;
      tick;
      if (cpu_en === 1'b1) begin
        en_cnt++;
        if (first_en < 0) first_en = i;
      end
      if (led[1] === 1'b1) led1_cnt++;
    end
    checks++; if (en_cnt != 1) begin errors++; $display("FAIL step_en_cycles: got %0d exp 1", en_cnt); end
    checks++; if (led1_cnt != 1) begin errors++; $display("FAIL step_led1_cycles: got %0d exp 1", led1_cnt); end
    checks++; if (first_en != 11) begin errors++; $display("FAIL step_latency: got %0d exp 11", first_en); end
    checks++; if (step_cnt !== 16'd1) begin errors++; $display("FAIL step_cnt: got %0d exp 1", step_cnt); end
    checks++; if (state !== 3'b001 || led !== 4'b0001) begin
      errors++; $display("FAIL step_back_wait: got st=%b led=%b exp st=001 led=0001", state, led);
    end
  endtask

  task automatic test_run;
    logic prev_led0;
    do_reset;
    halt_req = 1'b1;
    tick;
    halt_req = 1'b0;
    checks++; if (state !== 3'b001) begin errors++; $display("FAIL halt_in_wait: got %b exp 001", state); end
    prev_led0 = led[0];
    mode_run = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      if (k == 21) mode_run = 1'b0;
      tick;
      if (k <= 20) begin
        checks++; if (cpu_en !== 1'b1 || state !== 3'b010 || led[2] !== 1'b1) begin
          errors++; $display("FAIL run_en[%0d]: got en=%b st=%b led=%b exp en=1 st=010", k, cpu_en, state, led);
        end
      end
      checks++; if (step_cnt !== 16'(k - 1)) begin
        errors++; $display("FAIL run_cnt[%0d]: got %0d exp %0d", k, step_cnt, k - 1);
      end
      if (k >= 2) begin
        checks++; if (led[0] === prev_led0) begin
          errors++; $display("FAIL run_led0_toggle[%0d]: got %b exp %b", k, led[0], ~prev_led0);
        end
      end
      prev_led0 = led[0];
    end
    checks++; if (cpu_en !== 1'b0 || state !== 3'b001) begin
      errors++; $display("FAIL run_stop: got en=%b st=%b exp en=0 st=001", cpu_en, state);
    end
    checks++; if (step_cnt !== 16'd20 || led !== 4'b0000) begin
      errors++; $display("FAIL run_final: got cnt=%0d led=%b exp cnt=20 led=0000", step_cnt, led);
    end
  endtask

  task automatic test_halt;
    int init_at;
    init_at = -1;
    mode_run = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL halt_pre_run[%0d]: got %b exp 1", k, cpu_en); end
    end
    halt_req = 1'b1;
    tick;
    halt_req = 1'b0;
    checks++; if (state !== 3'b100 || cpu_en !== 1'b0) begin
      errors++; $display("FAIL halt_enter: got st=%b en=%b exp st=100 en=0", state, cpu_en);
    end
    checks++; if (led !== 4'b1000 || step_cnt !== 16'd26) begin
      errors++; $display("FAIL halt_outputs: got led=%b cnt=%0d exp led=1000 cnt=26", led, step_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      halt_req = (k == 2);
      tick;
      checks++; if (state !== 3'b100 || led !== 4'b1000) begin
        errors++; $display("FAIL halt_hold[%0d]: got st=%b led=%b exp st=100 led=1000", k, state, led);
      end
    end
    halt_req = 1'b0;
    mode_run = 1'b0;
    for (int i = 0; i < 30; i++) begin
      key_ok = (i < 8) ? 1'b0 : 1'b1;
      tick;
      if (state === 3'b000 && init_at < 0) begin
        init_at = i;
        checks++; if (step_cnt !== 16'd0 || cpu_rst !== 1'b1 || cpu_en !== 1'b0 || led !== 4'b0000) begin
          errors++; $display("FAIL restart_outputs: got cnt=%0d rst=%b en=%b led=%b exp 0/1/0/0000",
                             step_cnt, cpu_rst, cpu_en, led);
        end
      end
    end
    checks++; if (init_at != 7) begin errors++; $display("FAIL restart_latency: got %0d exp 7", init_at); end
    checks++; if (state !== 3'b001) begin errors++; $display("FAIL restart_wait: got %b exp 001", state); end
  endtask

  task automatic test_simultaneous;
    mode_run = 1'b1;
    tick;
    checks++; if (state !== 3'b010) begin errors++; $display("FAIL simul_run: got %b exp 010", state); end
    for (int i = 0; i < 20; i++) begin
      key_ok = (i < 8) ? 1'b0 : 1'b1;
      tick;
      checks++; if (state !== 3'b010) begin
        errors++; $display("FAIL key_in_run[%0d]: got %b exp 010", i, state);
      end
    end
    halt_req = 1'b1;
    mode_run = 1'b0;
    tick;
    halt_req = 1'b0;
    checks++; if (state !== 3'b100 || cpu_en !== 1'b0 || led[3:1] !== 3'b100) begin
      errors++; $display("FAIL halt_over_mode: got st=%b en=%b led=%b exp st=100 en=0", state, cpu_en, led);
    end
    repeat (3) tick;
    checks++; if (state !== 3'b100) begin errors++; $display("FAIL halt_stays: got %b exp 100", state); end
  endtask

  task automatic test_sat_abort;
    logic [3:0] exp_cnt;
    bit found;
    do_reset;
    mode_run = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      if (k == 21) mode_run = 1'b0;
      tick;
      exp_cnt = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
      checks++; if (s_step_cnt !== exp_cnt) begin
        errors++; $display("FAIL sat_cnt[%0d]: got %0d exp %0d", k, s_step_cnt, exp_cnt);
      end
    end
    checks++; if (s_state !== 3'b001 || s_step_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_final: got st=%b cnt=%0d exp st=001 cnt=15", s_state, s_step_cnt);
    end
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      key_ok = (i < 8) ? 1'b0 : 1'b1;
      tick;
      if (s_state === 3'b011) found = 1'b1;
    end
    key_ok = 1'b1;
    checks++; if (!found) begin errors++; $display("FAIL abort_step_entry: got timeout exp state 011"); end
    tick;
    checks++; if (s_cpu_en !== 1'b1 || s_state !== 3'b011) begin
      errors++; $display("FAIL abort_step2: got en=%b st=%b exp en=1 st=011", s_cpu_en, s_state);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (s_cpu_en !== 1'b0 || s_state !== 3'b000 || s_cpu_rst !== 1'b1 || s_step_cnt !== 4'd0) begin
      errors++; $display("FAIL abort_reset: got en=%b st=%b rst=%b cnt=%0d exp 0/000/1/0",
                         s_cpu_en, s_state, s_cpu_rst, s_step_cnt);
    end
    repeat (4) tick;
    for (int i = 0; i < 10; i++) begin
      checks++; if (s_cpu_en !== 1'b0 || s_state !== 3'b001) begin
        errors++; $display("FAIL abort_idle[%0d]: got en=%b st=%b exp en=0 st=001", i, s_cpu_en, s_state);
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_step;
    test_run;
    test_halt;
    test_simultaneous;
    test_sat_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
